// File: rtl/cas_sensor_sequencer.sv
// Conversion sequencer for the CAS sensor front end: excite, reset integrator,
// single-slope integrate and count until the synchronized comparator trips.
module cas_sensor_sequencer #(
    parameter int unsigned CNT_W         = 12,
    parameter int unsigned SETTLE_CYCLES = 64,
    parameter int unsigned RST_CYCLES    = 16,
    parameter int unsigned NUM_CH        = 4,
    parameter int unsigned CH_W          = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic             start,
    input  logic             abort,
    input  logic             scan_en,
    input  logic [CH_W-1:0]  ch_sel,
    input  logic             comp_in,
    output logic             excite_en,
    output logic             int_rst,
    output logic             int_en,
    output logic [CH_W-1:0]  ch_out,
    output logic             busy,
    output logic [CNT_W-1:0] result,
    output logic [CH_W-1:0]  result_ch,
    output logic             overflow,
    output logic             result_valid
);

    localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] SETTLE_END = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] RST_END    = CNT_W'(RST_CYCLES - 1);
    localparam logic [CH_W-1:0]  CH_LAST    = CH_W'(NUM_CH - 1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        EXCITE  = 3'd1,
        RST_INT = 3'd2,
        CONVERT = 3'd3,
        DONE    = 3'd4
    } state_t;

    state_t           state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [CH_W-1:0]  ch, ch_n;
    logic [CNT_W-1:0] result_n;
    logic [CH_W-1:0]  result_ch_n;
    logic             overflow_n;
    logic             comp_meta, comp_s;

    // Two-flop synchronizer; comp_in is asynchronous to clk
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            comp_meta <= 1'b0;
            comp_s    <= 1'b0;
        end else begin
            comp_meta <= comp_in;
            comp_s    <= comp_meta;
        end
    end

    // State, counters and registered outputs; outputs are decoded from state_n
    // so they line up exactly with the state they describe
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            cnt          <= '0;
            ch           <= '0;
            result       <= '0;
            result_ch    <= '0;
            overflow     <= 1'b0;
            busy         <= 1'b0;
            excite_en    <= 1'b0;
            int_rst      <= 1'b0;
            int_en       <= 1'b0;
            result_valid <= 1'b0;
        end else begin
            state        <= state_n;
            cnt          <= cnt_n;
            ch           <= ch_n;
            result       <= result_n;
            result_ch    <= result_ch_n;
            overflow     <= overflow_n;
            busy         <= (state_n != IDLE);
            excite_en    <= (state_n == EXCITE) || (state_n == RST_INT) || (state_n == CONVERT);
            int_rst      <= (state_n == RST_INT);
            int_en       <= (state_n == CONVERT);
            result_valid <= (state_n == DONE);
        end
    end

    assign ch_out = ch;

    always_comb begin
        state_n     = state;
        cnt_n       = CNT_W'(cnt + 1'b1);
        ch_n        = ch;
        result_n    = result;
        result_ch_n = result_ch;
        overflow_n  = overflow;

        case (state)
            IDLE: begin
                cnt_n = '0;
                if (start) begin
                    ch_n    = ch_sel;
                    state_n = EXCITE;
                end
            end
            EXCITE: begin
                if (cnt == SETTLE_END) begin
                    cnt_n   = '0;
                    state_n = RST_INT;
                end
            end
            RST_INT: begin
                if (cnt == RST_END) begin
                    cnt_n   = '0;
                    state_n = CONVERT;
                end
            end
            CONVERT: begin
                // A comparator trip takes priority over full scale in the same cycle
                if (comp_s) begin
                    result_n    = cnt;
                    result_ch_n = ch;
                    overflow_n  = 1'b0;
                    cnt_n       = '0;
                    state_n     = DONE;
                end else if (cnt == CNT_MAX) begin
                    result_n    = CNT_MAX;
                    result_ch_n = ch;
                    overflow_n  = 1'b1;
                    cnt_n       = '0;
                    state_n     = DONE;
                end
            end
            DONE: begin
                cnt_n = '0;
                if (scan_en) begin
                    ch_n    = (ch == CH_LAST) ? '0 : CH_W'(ch + 1'b1);
                    state_n = EXCITE;
                end else begin
                    state_n = IDLE;
                end
            end
            default: begin
                cnt_n   = '0;
                state_n = IDLE;
            end
        endcase

        // Abort or disable overrides everything; results keep their previous value
        if (abort || !ena) begin
            state_n     = IDLE;
            cnt_n       = '0;
            ch_n        = ch;
            result_n    = result;
            result_ch_n = result_ch;
            overflow_n  = overflow;
        end
    end

endmodule

// File: tb/tb_cas_sensor_sequencer.sv
// Directed bench for cas_sensor_sequencer: phase lengths, results, scan order,
// abort/disable, ignored start, back-to-back starts and async reset.
module tb_cas_sensor_sequencer;

    localparam int unsigned CNT_W = 12;
    localparam int unsigned CH_W  = 2;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             ena = 1'b0;
    logic             start = 1'b0;
    logic             abort = 1'b0;
    logic             scan_en = 1'b0;
    logic [CH_W-1:0]  ch_sel = '0;
    logic             comp_in = 1'b0;
    logic             excite_en, int_rst, int_en, busy, overflow, result_valid;
    logic [CH_W-1:0]  ch_out, result_ch;
    logic [CNT_W-1:0] result;

    int n_tests = 0;
    int n_fail  = 0;
    int n_valid = 0;
    bit excl_viol = 1'b0;

    cas_sensor_sequencer dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .ena          (ena),
        .start        (start),
        .abort        (abort),
        .scan_en      (scan_en),
        .ch_sel       (ch_sel),
        .comp_in      (comp_in),
        .excite_en    (excite_en),
        .int_rst      (int_rst),
        .int_en       (int_en),
        .ch_out       (ch_out),
        .busy         (busy),
        .result       (result),
        .result_ch    (result_ch),
        .overflow     (overflow),
        .result_valid (result_valid)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (result_valid) n_valid++;
        if (int_rst && int_en) excl_viol = 1'b1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    function automatic logic sig(input int sel);
        case (sel)
            0:       return result_valid;
            1:       return int_en;
            default: return int_rst;
        endcase
    endfunction

    // Waits (bounded) for the selected output; n = negedges waited
    task automatic wait_sig(input string tag, input int sel, input int max, output int n);
        n = 0;
        while (!sig(sel) && n < max) begin
            @(negedge clk);
            n++;
        end
        check(tag, 32'(sig(sel)), 1);
    endtask

    task automatic pulse_start(input logic [CH_W-1:0] ch);
        ch_sel = ch;
        start  = 1'b1;
        step(1);
        start  = 1'b0;
    endtask

    int n;
    int nv;
    int exp3 [5] = '{3, 0, 1, 2, 3};

    initial begin
        // Reset state
        step(2);
        check("rst_busy", 32'(busy), 0);
        check("rst_enables", 32'({excite_en, int_rst, int_en, result_valid, overflow}), 0);
        check("rst_result", 32'(result), 0);
        check("rst_ch", 32'({ch_out, result_ch}), 0);
        rst_n = 1'b1;
        ena   = 1'b1;
        step(2);

        // 1: single conversion, comparator rises 100 cycles into CONVERT
        pulse_start(2'd2);
        check("t1_busy", 32'(busy), 1);
        check("t1_excite", 32'(excite_en), 1);
        check("t1_ch_out", 32'(ch_out), 2);
        wait_sig("t1_to_rst", 2, 200, n);
        check("t1_excite_len", 32'(n), 64);
        wait_sig("t1_to_conv", 1, 200, n);
        check("t1_rst_len", 32'(n), 16);
        step(100);
        comp_in = 1'b1;
        wait_sig("t1_to_done", 0, 200, n);
        check("t1_result_range", 32'(result >= 101 && result <= 102), 1);
        check("t1_result", 32'(result), 102);
        check("t1_result_ch", 32'(result_ch), 2);
        check("t1_overflow", 32'(overflow), 0);
        check("t1_done_enables", 32'({excite_en, int_rst, int_en}), 0);
        comp_in = 1'b0;
        step(1);
        check("t1_idle", 32'({busy, result_valid}), 0);
        step(3);

        // 2: comparator never trips -> full scale
        pulse_start(2'd1);
        wait_sig("t2_to_conv", 1, 200, n);
        wait_sig("t2_to_done", 0, 5000, n);
        check("t2_conv_len", 32'(n), 4096);
        check("t2_result", 32'(result), 32'hFFF);
        check("t2_overflow", 32'(overflow), 1);
        check("t2_result_ch", 32'(result_ch), 1);
        step(3);

        // 3: round-robin scan from channel 3, comparator already high at CONVERT entry
        scan_en = 1'b1;
        comp_in = 1'b1;
        pulse_start(2'd3);
        for (int k = 0; k < 5; k++) begin
            wait_sig("t3_to_done", 0, 200, n);
            check("t3_result_ch", 32'(result_ch), 32'(exp3[k]));
            check("t3_result", 32'(result), 0);
            check("t3_overflow", 32'(overflow), 0);
            if (k == 4) scan_en = 1'b0;
            step(1);
            check("t3_busy_after_done", 32'(busy), (k < 4) ? 32'd1 : 32'd0);
        end
        step(3);

        // 4: abort mid-CONVERT
        comp_in = 1'b0;
        pulse_start(2'd1);
        wait_sig("t4_to_conv", 1, 200, n);
        step(50);
        abort = 1'b1;
        step(1);
        abort = 1'b0;
        check("t4_busy", 32'(busy), 0);
        check("t4_enables", 32'({excite_en, int_rst, int_en, result_valid}), 0);
        check("t4_result_kept", 32'({overflow, result_ch, result}), 32'({1'b0, 2'd3, 12'd0}));
        check("t4_ch_out_hold", 32'(ch_out), 1);
        nv = n_valid;
        step(20);
        check("t4_no_valid", 32'(n_valid - nv), 0);

        // ena low during EXCITE acts as abort
        pulse_start(2'd1);
        step(5);
        ena = 1'b0;
        step(1);
        ena = 1'b1;
        check("ena_abort", 32'({busy, excite_en}), 0);
        step(2);

        // start held high in IDLE: back-to-back conversions, one IDLE cycle between
        comp_in = 1'b1;
        ch_sel  = 2'd2;
        start   = 1'b1;
        step(1);
        wait_sig("b2b_to_done", 0, 200, n);
        step(1);
        check("b2b_idle", 32'(busy), 0);
        step(1);
        check("b2b_restart", 32'({busy, excite_en, ch_out}), 32'({1'b1, 1'b1, 2'd2}));
        start = 1'b0;
        wait_sig("b2b_to_done2", 0, 200, n);
        step(3);

        // 5: start during EXCITE is ignored; comparator rises 30 cycles into CONVERT
        comp_in = 1'b0;
        nv = n_valid;
        pulse_start(2'd3);
        step(10);
        pulse_start(2'd0);
        check("t5_ch_out", 32'(ch_out), 3);
        wait_sig("t5_to_conv", 1, 200, n);
        step(30);
        comp_in = 1'b1;
        wait_sig("t5_to_done", 0, 200, n);
        check("t5_result", 32'(result), 32);
        check("t5_result_ch", 32'(result_ch), 3);
        step(100);
        check("t5_one_valid", 32'(n_valid - nv), 1);
        check("t5_idle", 32'(busy), 0);

        // async reset mid-RST_INT clears everything including results
        comp_in = 1'b0;
        pulse_start(2'd2);
        wait_sig("t5_to_rst", 2, 200, n);
        step(3);
        #2 rst_n = 1'b0;
        #1;
        check("arst_enables", 32'({busy, excite_en, int_rst, int_en, result_valid, overflow}), 0);
        check("arst_result", 32'(result), 0);
        check("arst_ch", 32'({ch_out, result_ch}), 0);
        step(2);
        rst_n = 1'b1;
        step(2);

        // 6: int_rst and int_en never high together
        check("int_exclusive", 32'(excl_viol), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
